// File: rtl/rps_match_sequencer_if.sv
// Player/core-facing signal bundle of the stone-paper-scissors match sequencer.
// master = the sequencer itself, slave = the player switches plus the game core.
interface rps_match_sequencer_if #(
    parameter int unsigned SCORE_W = 3
);
    logic               go;
    logic               mode;
    logic [1:0]         p1_sel;
    logic [1:0]         p2_sel;
    logic [1:0]         winner;
    logic               start;
    logic [1:0]         p1_move;
    logic [1:0]         p2_move;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [3:0]         round_cnt;
    logic               match_over;
    logic [1:0]         match_winner;
    logic               err;
    logic [2:0]         seq_state;

    modport master (
        input  go, mode, p1_sel, p2_sel, winner,
        output start, p1_move, p2_move, p1_score, p2_score, round_cnt,
               match_over, match_winner, err, seq_state
    );

    modport slave (
        output go, mode, p1_sel, p2_sel, winner,
        input  start, p1_move, p2_move, p1_score, p2_score, round_cnt,
               match_over, match_winner, err, seq_state
    );
endinterface

// File: rtl/rps_match_sequencer.sv
// Initiator side of the stone-paper-scissors core: turns player commits into round strobes,
// scores best-of-N matches and supplies an LFSR computer move in mode 1.
module rps_match_sequencer #(
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned RESULT_LAT    = 2,
    parameter int unsigned SCORE_W       = 3,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    rps_match_sequencer_if.master bus
);
    localparam int unsigned CNT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        SCORE = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e             state_q;
    logic               go_q;
    logic               arm_q;
    logic [7:0]         lfsr_q;
    logic [7:0]         lfsr_d;
    logic               mode_q;
    logic [CNT_W-1:0]   wcnt_q;
    logic [1:0]         winner_q;
    logic               start_q;
    logic [1:0]         p1_move_q;
    logic [1:0]         p2_move_q;
    logic [SCORE_W-1:0] p1_score_q;
    logic [SCORE_W-1:0] p2_score_q;
    logic [SCORE_W-1:0] p1_score_d;
    logic [SCORE_W-1:0] p2_score_d;
    logic [3:0]         round_q;
    logic               over_q;
    logic [1:0]         mwin_q;
    logic               err_q;

    logic               go_rise;
    logic               mode_d;
    logic               sel_bad;
    logic [1:0]         cpu_move;

    always_comb begin
        // arm_q blocks a go that is already high when reset releases from counting as an edge
        go_rise    = bus.go & ~go_q & arm_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cpu_move   = (lfsr_q[1:0] == 2'b11) ? 2'b00 : lfsr_q[1:0];
        mode_d     = (round_q == 4'd0) ? bus.mode : mode_q;
        sel_bad    = (bus.p1_sel == 2'b11) || (!mode_d && (bus.p2_sel == 2'b11));
        p1_score_d = p1_score_q + SCORE_W'(winner_q == 2'b01);
        p2_score_d = p2_score_q + SCORE_W'(winner_q == 2'b10);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            go_q       <= 1'b0;
            arm_q      <= 1'b0;
            lfsr_q     <= LFSR_SEED;
            mode_q     <= 1'b0;
            wcnt_q     <= '0;
            winner_q   <= '0;
            start_q    <= 1'b0;
            p1_move_q  <= '0;
            p2_move_q  <= '0;
            p1_score_q <= '0;
            p2_score_q <= '0;
            round_q    <= '0;
            over_q     <= 1'b0;
            mwin_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            go_q    <= bus.go;
            arm_q   <= arm_q | ~bus.go;
            lfsr_q  <= lfsr_d;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_rise) begin
                        if (round_q == 4'd0) mode_q <= bus.mode;
                        if (sel_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            p1_move_q <= bus.p1_sel;
                            p2_move_q <= mode_d ? cpu_move : bus.p2_sel;
                            start_q   <= 1'b1;
                            state_q   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wcnt_q  <= CNT_W'(RESULT_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (wcnt_q == '0) begin
                        winner_q <= bus.winner;
                        state_q  <= SCORE;
                    end else begin
                        wcnt_q <= wcnt_q - CNT_W'(1);
                    end
                end
                SCORE: begin
                    p1_score_q <= p1_score_d;
                    p2_score_q <= p2_score_d;
                    err_q      <= (winner_q == 2'b11);
                    if (round_q != 4'hF) round_q <= round_q + 4'd1;
                    if (p1_score_d == SCORE_W'(ROUNDS_TO_WIN)) begin
                        over_q  <= 1'b1;
                        mwin_q  <= 2'b01;
                        state_q <= DONE;
                    end else if (p2_score_d == SCORE_W'(ROUNDS_TO_WIN)) begin
                        over_q  <= 1'b1;
                        mwin_q  <= 2'b10;
                        state_q <= DONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    if (go_rise) begin
                        p1_score_q <= '0;
                        p2_score_q <= '0;
                        round_q    <= '0;
                        over_q     <= 1'b0;
                        mwin_q     <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.start        = start_q;
    assign bus.p1_move      = p1_move_q;
    assign bus.p2_move      = p2_move_q;
    assign bus.p1_score     = p1_score_q;
    assign bus.p2_score     = p2_score_q;
    assign bus.round_cnt    = round_q;
    assign bus.match_over   = over_q;
    assign bus.match_winner = mwin_q;
    assign bus.err          = err_q;
    assign bus.seq_state    = 3'(state_q);
endmodule

// File: tb/tb_rps_match_sequencer.sv
// Bench for rps_match_sequencer: directed match scenarios plus randomized rounds against a
// score-keeping reference model and a latency-accurate model of the game core.
module tb_rps_match_sequencer;
    localparam int unsigned RTW = 2;
    localparam int unsigned RL  = 2;
    localparam int unsigned SW  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rps_match_sequencer_if #(.SCORE_W(SW)) bus ();

    rps_match_sequencer #(
        .ROUNDS_TO_WIN(RTW),
        .RESULT_LAT   (RL),
        .SCORE_W      (SW),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned start_cnt   = 0;
    int          cd          = -1;
    logic [1:0]  core_win    = 2'b00;

    // reference model state
    logic [7:0]  m_lfsr;
    int unsigned m_p1, m_p2, m_rounds;
    logic        m_over, m_mode;
    logic [1:0]  m_mw, m_p1mv, m_p2mv;

    // polynomial x^8+x^6+x^5+x^4+1 as a feedback mask over bits 7,5,4,3
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    // game core: winner is valid only in cycle C+RL; 11 everywhere else
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            cd         = -1;
            bus.winner = 2'b11;
        end else begin
            if (bus.start) begin
                start_cnt++;
                cd = int'(RL);
            end else if (cd > 0) begin
                cd--;
            end
            bus.winner = (cd == 0) ? core_win : 2'b11;
            if (cd == 0) cd = -1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_rounds = 0;
        m_over = 1'b0; m_mode = 1'b0; m_mw = 2'b00;
        m_p1mv = 2'b00; m_p2mv = 2'b00;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_p1_score"}, 8'(bus.p1_score), 8'(m_p1));
        check({tag, "_p2_score"}, 8'(bus.p2_score), 8'(m_p2));
        check({tag, "_round_cnt"}, 8'(bus.round_cnt), 8'(m_rounds));
        check({tag, "_match_over"}, 8'(bus.match_over), 8'(m_over));
        check({tag, "_match_winner"}, 8'(bus.match_winner), 8'(m_mw));
        check({tag, "_seq_state"}, 8'(bus.seq_state), m_over ? 8'd4 : 8'd0);
    endtask

    // One go edge with the given switches and the winner the core will report.
    task automatic play(input logic [1:0] p1, input logic [1:0] p2, input logic md,
                        input logic [1:0] w);
        logic [1:0]  cpu;
        logic        eff;
        logic        exp_err;
        int unsigned s0;
        bus.p1_sel = p1;
        bus.p2_sel = p2;
        bus.mode   = md;
        core_win   = w;
        cpu        = (m_lfsr[1:0] == 2'b11) ? 2'b00 : m_lfsr[1:0];
        s0         = start_cnt;
        bus.go     = 1'b1;
        tick(1);
        bus.go     = 1'b0;
        if (m_over) begin
            m_p1 = 0; m_p2 = 0; m_rounds = 0; m_over = 1'b0; m_mw = 2'b00;
            check("clr_start", 8'(bus.start), 8'd0);
            check_all("clr");
            tick(RL + 3);
            check("clr_no_round", 8'(start_cnt), 8'(s0));
        end else begin
            eff = (m_rounds == 0) ? md : m_mode;
            if (m_rounds == 0) m_mode = md;
            if (p1 == 2'b11 || (!eff && p2 == 2'b11)) begin
                check("sel_err", 8'(bus.err), 8'd1);
                check("sel_err_start", 8'(bus.start), 8'd0);
                check("sel_err_state", 8'(bus.seq_state), 8'd0);
                check("sel_err_p1_move", 8'(bus.p1_move), 8'(m_p1mv));
                check("sel_err_p2_move", 8'(bus.p2_move), 8'(m_p2mv));
                tick(1);
                check("sel_err_pulse", 8'(bus.err), 8'd0);
                check("sel_err_no_round", 8'(start_cnt), 8'(s0));
            end else begin
                m_p1mv = p1;
                m_p2mv = eff ? cpu : p2;
                check("start", 8'(bus.start), 8'd1);
                check("start_p1_move", 8'(bus.p1_move), 8'(m_p1mv));
                check("start_p2_move", 8'(bus.p2_move), 8'(m_p2mv));
                check("start_state", 8'(bus.seq_state), 8'd1);
                tick(RL + 2);
                exp_err = (w == 2'b11);
                if (m_rounds < 15) m_rounds++;
                if (w == 2'b01) m_p1++;
                else if (w == 2'b10) m_p2++;
                if (m_p1 == RTW) begin
                    m_over = 1'b1; m_mw = 2'b01;
                end else if (m_p2 == RTW) begin
                    m_over = 1'b1; m_mw = 2'b10;
                end
                check("score_err", 8'(bus.err), 8'(exp_err));
                check_all("score");
                check("held_p1_move", 8'(bus.p1_move), 8'(m_p1mv));
                check("held_p2_move", 8'(bus.p2_move), 8'(m_p2mv));
                check("one_start", 8'(start_cnt), 8'(s0 + 1));
                tick(1);
                check("score_err_pulse", 8'(bus.err), 8'd0);
            end
        end
    endtask

    initial begin
        int unsigned s0;
        model_reset();
        bus.go     = 1'b1;
        bus.mode   = 1'b0;
        bus.p1_sel = 2'b00;
        bus.p2_sel = 2'b00;

        // reset with go held high, then release while go is still high
        tick(2);
        check("rst_start", 8'(bus.start), 8'd0);
        check("rst_p1_move", 8'(bus.p1_move), 8'd0);
        check("rst_p2_move", 8'(bus.p2_move), 8'd0);
        check("rst_err", 8'(bus.err), 8'd0);
        check_all("rst");
        reset = 1'b1;
        tick(4);
        check("rst_release_no_start", 8'(start_cnt), 8'd0);
        check("rst_release_state", 8'(bus.seq_state), 8'd0);
        bus.go = 1'b0;
        tick(2);

        // rock vs scissors, P1 wins; tie; P1 wins again -> match over
        play(2'b00, 2'b10, 1'b0, 2'b01);
        play(2'b00, 2'b00, 1'b0, 2'b00);
        play(2'b01, 2'b00, 1'b0, 2'b01);
        tick(3);
        check("done_hold_over", 8'(bus.match_over), 8'd1);
        play(2'b00, 2'b00, 1'b0, 2'b00);
        play(2'b10, 2'b01, 1'b0, 2'b01);

        // invalid selection, then invalid winner code from the core
        play(2'b11, 2'b00, 1'b0, 2'b00);
        play(2'b00, 2'b00, 1'b0, 2'b11);
        play(2'b01, 2'b00, 1'b0, 2'b01);
        play(2'b00, 2'b00, 1'b0, 2'b00);

        // computer opponent; mode flipped mid-match stays latched
        play(2'b01, 2'b11, 1'b1, 2'b10);
        play(2'b10, 2'b11, 1'b0, 2'b10);
        play(2'b00, 2'b00, 1'b0, 2'b00);

        // ties until the round counter saturates
        for (int unsigned i = 0; i < 17; i++) play(2'b00, 2'b00, 1'b0, 2'b00);

        for (int unsigned i = 0; i < 60; i++)
            play(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        if (m_over) play(2'b00, 2'b00, 1'b0, 2'b00);
        if (m_rounds != 0) begin
            // finish the ongoing match so the next steps start fresh
            while (!m_over) play(2'b01, 2'b00, 1'b0, 2'b01);
            play(2'b00, 2'b00, 1'b0, 2'b00);
        end

        // go held high for 20 cycles yields exactly one round
        bus.p1_sel = 2'b00;
        bus.p2_sel = 2'b01;
        bus.mode   = 1'b0;
        core_win   = 2'b00;
        m_mode     = 1'b0;
        s0         = start_cnt;
        bus.go     = 1'b1;
        tick(20);
        bus.go     = 1'b0;
        tick(3);
        m_rounds++;
        check("held_go_one_start", 8'(start_cnt), 8'(s0 + 1));
        check_all("held_go");

        // reset asserted while the round is waiting on the core
        play(2'b01, 2'b00, 1'b0, 2'b01);
        bus.p1_sel = 2'b10;
        bus.p2_sel = 2'b01;
        core_win   = 2'b01;
        bus.go     = 1'b1;
        tick(1);
        bus.go     = 1'b0;
        tick(1);
        check("pre_rst_state", 8'(bus.seq_state), 8'd2);
        reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_start", 8'(bus.start), 8'd0);
        check("mid_rst_p1_move", 8'(bus.p1_move), 8'd0);
        check_all("mid_rst");
        tick(1);
        reset = 1'b1;
        tick(RL + 3);
        check("post_rst_no_start", 8'(bus.start), 8'd0);
        check_all("post_rst");
        play(2'b00, 2'b10, 1'b1, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
